// File: rtl/irq_pending_ctrl_pkg.sv
// Shared constants and FSM state type for the pending-interrupt controller.
package irq_pending_ctrl_pkg;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    CLEAR  = 2'd2
  } state_e;
endpackage

// File: rtl/irq_prio_enc.sv
// Combinational highest-index-wins encoder over a request vector.
module irq_prio_enc #(
  parameter int NREQ = irq_pending_ctrl_pkg::NREQ,
  parameter int IDW  = irq_pending_ctrl_pkg::IDW
) (
  input  logic [NREQ-1:0] vec,
  output logic [IDW-1:0]  id,
  output logic            any
);
  // Ascending scan so the last (highest) set bit overwrites lower ones.
  always_comb begin
    id  = '0;
    any = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (vec[k]) begin
        id  = IDW'(k);
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/irq_pending_ctrl.sv
// Edge-triggered pending-interrupt controller: latches request edges, presents the
// highest-priority unmasked source and retires it on ack. state_dbg exposes the FSM.
//
// Handshake: irq_valid/irq_id are a registered offer; ack is honoured only in the
// cycle irq_valid=1 with en=1, and retires exactly the presented irq_id.
module irq_pending_ctrl #(
  parameter int NREQ = irq_pending_ctrl_pkg::NREQ,
  parameter int IDW  = irq_pending_ctrl_pkg::IDW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] mask,
  input  logic            ack,
  input  logic            ovr_clr,
  output logic            irq_valid,
  output logic [IDW-1:0]  irq_id,
  output logic [NREQ-1:0] pending,
  output logic [NREQ-1:0] ovr,
  output logic [1:0]      state_dbg
);
  import irq_pending_ctrl_pkg::*;

  state_e          state_q, state_d;
  logic [NREQ-1:0] req_q, req_d;
  logic [NREQ-1:0] pending_q, pending_d;
  logic [NREQ-1:0] ovr_q, ovr_d;
  logic [IDW-1:0]  irq_id_q, irq_id_d;
  logic            irq_valid_q, irq_valid_d;

  logic [NREQ-1:0] edge_v, set_v, clr_v;
  logic            ack_fire;
  logic [IDW-1:0]  win_id;
  logic            win_any;

  irq_prio_enc #(.NREQ(NREQ), .IDW(IDW)) u_prio (
    .vec (pending_q & mask),
    .id  (win_id),
    .any (win_any)
  );

  always_comb begin
    req_d    = req;
    edge_v   = req & ~req_q;
    set_v    = en ? edge_v : '0;
    ack_fire = (state_q == ASSERT) && en && ack;
    clr_v    = ack_fire ? (NREQ'(1) << irq_id_q) : '0;
    // A fresh edge re-sets a bit cleared in the same cycle; only a hit on a
    // still-pending bit counts as an overrun.
    pending_d = (pending_q & ~clr_v) | set_v;
    ovr_d     = (ovr_clr ? '0 : ovr_q) | (set_v & pending_q & ~clr_v);

    state_d  = state_q;
    irq_id_d = irq_id_q;
    case (state_q)
      IDLE: begin
        if (en && win_any) begin
          irq_id_d = win_id;
          state_d  = ASSERT;
        end
      end
      ASSERT: begin
        if (!en)          state_d = IDLE;
        else if (ack)     state_d = CLEAR;
      end
      CLEAR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    irq_valid_d = (state_d == ASSERT);
  end

  always_ff @(posedge clk) begin
    req_q <= req_d;
    if (rst) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      ovr_q       <= '0;
      irq_id_q    <= '0;
      irq_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      ovr_q       <= ovr_d;
      irq_id_q    <= irq_id_d;
      irq_valid_q <= irq_valid_d;
    end
  end

  assign irq_valid = irq_valid_q;
  assign irq_id    = irq_id_q;
  assign pending   = pending_q;
  assign ovr       = ovr_q;
  assign state_dbg = state_q;
endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Scoreboard bench for irq_pending_ctrl: a behavioural model predicts the outputs
// after every clock edge and a monitor compares them.
module tb_irq_pending_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] mask = '0;
  logic       ack = 1'b0;
  logic       ovr_clr = 1'b0;
  logic       irq_valid;
  logic [1:0] irq_id;
  logic [3:0] pending;
  logic [3:0] ovr;
  logic [1:0] state_dbg;

  logic [10:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  // Reference model: what the outputs must look like after the coming edge.
  bit [3:0] m_prev = '0;
  bit [3:0] m_pend = '0;
  bit [3:0] m_ovr = '0;
  bit [1:0] m_id = '0;
  bit       m_present = 1'b0;
  bit       m_cool = 1'b0;

  irq_pending_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req       (req),
    .mask      (mask),
    .ack       (ack),
    .ovr_clr   (ovr_clr),
    .irq_valid (irq_valid),
    .irq_id    (irq_id),
    .pending   (pending),
    .ovr       (ovr),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic step(input bit r, input bit e, input logic [3:0] rq,
                      input logic [3:0] mk, input bit a, input bit oc);
    bit [3:0] ev;
    int       win;
    bit       fire;
    @(negedge clk);
    rst = r; en = e; req = rq; mask = mk; ack = a; ovr_clr = oc;
    if (r) begin
      m_pend = '0; m_ovr = '0; m_id = '0; m_present = 1'b0; m_cool = 1'b0;
    end else begin
      win = -1;
      for (int k = 0; k < 4; k++) if (m_pend[k] && mk[k]) win = k;
      fire = m_present && e && a;
      if (oc) m_ovr = '0;
      ev = '0;
      for (int k = 0; k < 4; k++) begin
        ev[k] = e && rq[k] && !m_prev[k];
        if (ev[k] && m_pend[k] && !(fire && m_id == k)) m_ovr[k] = 1'b1;
      end
      if (fire) m_pend[m_id] = 1'b0;
      m_pend = m_pend | ev;
      if (m_present) begin
        if (!e) m_present = 1'b0;
        else if (a) begin m_present = 1'b0; m_cool = 1'b1; end
      end else if (m_cool) begin
        m_cool = 1'b0;
      end else if (e && win >= 0) begin
        m_present = 1'b1;
        m_id = win[1:0];
      end
    end
    m_prev = rq;
    exp_q.push_back({m_present, m_id, m_pend, m_ovr});
    @(posedge clk);
  endtask

  task automatic run(input logic [3:0] rq, input logic [3:0] mk, input bit a);
    step(1'b0, 1'b1, rq, mk, a, 1'b0);
  endtask

  // Monitor: one expected entry per edge, checked 1 time unit after it.
  initial begin
    logic [10:0] exp_v, got_v;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        got_v = {irq_valid, irq_id, pending, ovr};
        n_vec++;
        if (got_v !== exp_v) begin
          n_err++;
          $display("FAIL out_chk @%0t: got v=%0b id=%0d pend=%b ovr=%b, required v=%0b id=%0d pend=%b ovr=%b",
                   $time, got_v[10], got_v[9:8], got_v[7:4], got_v[3:0],
                   exp_v[10], exp_v[9:8], exp_v[7:4], exp_v[3:0]);
        end
      end
    end
  end

  initial begin
    // Reset with all lines high: no edges afterwards.
    repeat (3) step(1'b1, 1'b1, 4'b1111, 4'b1111, 1'b0, 1'b0);
    repeat (3) run(4'b1111, 4'b1111, 1'b0);
    run(4'b0000, 4'b1111, 1'b0);
    // Single source 2, ack, quiet afterwards.
    run(4'b0100, 4'b1111, 1'b0);
    run(4'b0000, 4'b1111, 1'b0);
    run(4'b0000, 4'b1111, 1'b1);
    repeat (3) run(4'b0000, 4'b1111, 1'b0);
    // Two sources together: 3 first, then 1.
    run(4'b1010, 4'b1111, 1'b0);
    run(4'b0000, 4'b1111, 1'b0);
    run(4'b0000, 4'b1111, 1'b1);
    run(4'b0000, 4'b1111, 1'b0);
    run(4'b0000, 4'b1111, 1'b0);
    run(4'b0000, 4'b1111, 1'b1);
    repeat (2) run(4'b0000, 4'b1111, 1'b0);
    // Masked source 3, then unmasked.
    run(4'b1000, 4'b0111, 1'b0);
    repeat (3) run(4'b0000, 4'b0111, 1'b0);
    run(4'b0000, 4'b1111, 1'b0);
    run(4'b0000, 4'b1111, 1'b0);
    // Mask change during ASSERT keeps the offer.
    run(4'b0000, 4'b0000, 1'b0);
    run(4'b0000, 4'b1111, 1'b1);
    repeat (2) run(4'b0000, 4'b1111, 1'b0);
    // Overrun on source 0, then clear.
    run(4'b0001, 4'b1111, 1'b0);
    run(4'b0000, 4'b1111, 1'b0);
    run(4'b0001, 4'b1111, 1'b0);
    run(4'b0000, 4'b1111, 1'b0);
    step(1'b0, 1'b1, 4'b0000, 4'b1111, 1'b0, 1'b1);
    run(4'b0000, 4'b1111, 1'b1);
    repeat (2) run(4'b0000, 4'b1111, 1'b0);
    // Ack of source 2 coinciding with a new edge on 2.
    run(4'b0100, 4'b1111, 1'b0);
    run(4'b0000, 4'b1111, 1'b0);
    run(4'b0100, 4'b1111, 1'b1);
    repeat (3) run(4'b0000, 4'b1111, 1'b0);
    run(4'b0000, 4'b1111, 1'b1);
    run(4'b0000, 4'b1111, 1'b0);
    // en=0 during ASSERT withdraws the offer but keeps pending.
    run(4'b0001, 4'b1111, 1'b0);
    run(4'b0000, 4'b1111, 1'b0);
    step(1'b0, 1'b0, 4'b0000, 4'b1111, 1'b1, 1'b0);
    step(1'b0, 1'b0, 4'b0010, 4'b1111, 1'b0, 1'b0);
    repeat (2) run(4'b0000, 4'b1111, 1'b0);
    // Reset during ASSERT drops everything.
    run(4'b1000, 4'b1111, 1'b0);
    run(4'b0000, 4'b1111, 1'b0);
    step(1'b1, 1'b1, 4'b0000, 4'b1111, 1'b0, 1'b0);
    repeat (2) run(4'b0000, 4'b1111, 1'b0);
    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) < 2),
           ($urandom_range(0, 9) != 0),
           4'($urandom_range(0, 15)),
           ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b1111,
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 15) == 0));
    end
    #5;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected entries left unchecked, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/irq_pending_ctrl.md
IRQ_PENDING_CTRL -- requirements
Module: irq_pending_ctrl

Interface
REQ-001 Parameter: NREQ, default 4, number of request sources; 4 is the only supported value.
REQ-002 Parameter: IDW, default 2, width of irq_id, equal to clog2(NREQ).
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: en  input  1  block enable; 0 ignores new edges and withdraws the request.
REQ-006 Port: req  input  NREQ  level request lines; a rising edge marks an event.
REQ-007 Port: mask  input  NREQ  per-source enable; 1 means allowed to raise an interrupt.
REQ-008 Port: ack  input  1  single-cycle acknowledge of the currently presented irq_id.
REQ-009 Port: ovr_clr  input  1  clears all overrun flags.
REQ-010 Port: irq_valid  output  1  an interrupt is presented.
REQ-011 Port: irq_id  output  IDW  presented source index; stable while irq_valid=1.
REQ-012 Port: pending  output  NREQ  registered pending bits, unmasked view.
REQ-013 Port: ovr  output  NREQ  sticky overrun flags.

Function
REQ-014 Edge detect SHALL be edge = req & ~req_q, where req_q is req registered every cycle.
REQ-015 When en=1, edge[k]=1 SHALL set pending[k] at that same clock edge; edges while en=0 SHALL be dropped.
REQ-016 Priority SHALL favour the highest index, so source 3 wins over sources 2, 1 and 0, among bits of pending & mask.
REQ-017 The FSM SHALL have exactly three states: IDLE, ASSERT and CLEAR.
REQ-018 In IDLE with en=1 and |(pending & mask)=1, the block SHALL capture the winning index into irq_id and enter ASSERT; otherwise it stays in IDLE.
REQ-019 irq_valid SHALL equal 1 exactly when the state is ASSERT.
REQ-020 Latency: req rising before edge t sets pending after edge t, and irq_valid SHALL be 1 after edge t+1.
REQ-021 In ASSERT, ack=1 SHALL clear pending[irq_id] and move the FSM to CLEAR.
REQ-022 CLEAR SHALL last one cycle with irq_valid=0, then move to IDLE.
REQ-023 In ASSERT, en=0 SHALL return the FSM to IDLE without clearing pending.
REQ-024 Mask or priority changes during ASSERT SHALL NOT change irq_id or withdraw irq_valid.
REQ-025 ack in IDLE or CLEAR SHALL be ignored.
REQ-026 When ack clears source k and edge[k]=1 in the same cycle, set SHALL win: pending[k] stays 1 and ovr[k] is unchanged.
REQ-027 When edge[k]=1 with pending[k] already 1 and not cleared that cycle, ovr[k] SHALL become 1 and stay set.
REQ-028 ovr_clr=1 SHALL zero ovr; a new overrun in the same cycle SHALL take priority and set its bit.
REQ-029 irq_id SHALL hold its last value outside ASSERT.

Reset
REQ-030 While rst=1, pending, ovr and irq_id SHALL be 0, irq_valid SHALL be 0 and the state SHALL be IDLE.
REQ-031 While rst=1, req_q SHALL load req, so a line held high through reset produces no edge.
REQ-032 rst asserted mid-operation, including in ASSERT, SHALL take effect at the next clock edge and discard all pending events.

Structure
REQ-033 A shared package SHALL hold the NREQ and IDW constants and the state enum (IDLE, ASSERT, CLEAR).
REQ-034 The highest-index-wins selection SHALL be a combinational sub-module, irq_prio_enc, with inputs vec[NREQ-1:0] and outputs id[IDW-1:0] and any.
REQ-035 All outputs SHALL be driven from registers, with no combinational path from input to output.

Verification
REQ-036 Scenario: after reset with en=1 and mask=4'b1111, pulse req=4'b0100 → pending=4'b0100 after 1 cycle, then irq_valid=1 and irq_id=2 the next cycle; ack → pending=0 and irq_valid=0 for at least 2 cycles.
REQ-037 Scenario: req rises 4'b1010 in a single cycle → irq_id=3 is presented first; after ack and CLEAR, irq_id=1 is presented.
REQ-038 Scenario: mask=4'b0111 and req rises 4'b1000 → pending=4'b1000 and irq_valid stays 0; then set mask=4'b1111 → irq_valid=1 and irq_id=3.
REQ-039 Scenario: source 0 is pending, then a second rising edge on req[0] arrives before ack → ovr=4'b0001; ovr_clr → ovr=0.
REQ-040 Scenario: ack for irq_id=2 arrives in the same cycle as a new edge on req[2] → pending[2] stays 1, ovr[2]=0, and irq_id=2 is presented again after CLEAR.
REQ-041 Scenario: req=4'b1111 held through reset, then rst released → no pending bits set; en=0 while in ASSERT → irq_valid drops next cycle and pending is kept.
